// File: rtl/apb_arbiter_if.sv
// APB bus bundle used on both sides of the arbiter: the "master" modport drives
// the request, the "slave" modport returns the response.
interface apb_arbiter_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_arbiter.sv
// Two-master round-robin APB arbiter in front of a single memory slave, with a
// per-transfer ACCESS timeout that completes the owner with an error.
module apb_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic          pclk_i,
    input  logic          preset_i,
    apb_arbiter_if.slave  m0,
    apb_arbiter_if.slave  m1,
    apb_arbiter_if.master mem,
    output logic [1:0]    gnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_m1;
    logic          psel_q;
    logic          penable_q;
    logic          pwrite_q;
    logic [7:0]    paddr_q;
    logic [31:0]   pwdata_q;

    // On a tie the master not served last wins; a lone requester always wins.
    logic pick_m1;
    assign pick_m1 = m1.psel && (!m0.psel || !last_m1);

    logic cnt_last;
    assign cnt_last = (cnt == TO_LAST);

    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state     <= IDLE;
            cnt       <= '0;
            last_m1   <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            gnt_o     <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (m0.psel || m1.psel) begin
                        state     <= SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        last_m1   <= pick_m1;
                        gnt_o     <= pick_m1 ? 2'b10 : 2'b01;
                        pwrite_q  <= pick_m1 ? m1.pwrite : m0.pwrite;
                        paddr_q   <= pick_m1 ? m1.paddr  : m0.paddr;
                        pwdata_q  <= pick_m1 ? m1.pwdata : m0.pwdata;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    penable_q <= 1'b1;
                    cnt       <= '0;
                end
                ACCESS: begin
                    if (mem.pready || cnt_last) begin
                        state     <= IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        gnt_o     <= 2'b00;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    gnt_o     <= 2'b00;
                end
            endcase
        end
    end

    assign mem.psel    = psel_q;
    assign mem.penable = penable_q;
    assign mem.pwrite  = pwrite_q;
    assign mem.paddr   = paddr_q;
    assign mem.pwdata  = pwdata_q;

    // Completion is either a slave pready or a timeout; reset suppresses both.
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    assign resp_valid = !preset_i && (state == ACCESS) && (mem.pready || cnt_last);
    assign resp_data  = mem.pready ? mem.prdata : 32'h0;
    assign resp_err   = mem.pready ? mem.pslverr : 1'b1;

    assign m0.pready  = resp_valid && gnt_o[0];
    assign m0.pslverr = resp_valid && gnt_o[0] && resp_err;
    assign m0.prdata  = (resp_valid && gnt_o[0]) ? resp_data : 32'h0;

    assign m1.pready  = resp_valid && gnt_o[1];
    assign m1.pslverr = resp_valid && gnt_o[1] && resp_err;
    assign m1.prdata  = (resp_valid && gnt_o[1]) ? resp_data : 32'h0;

    // penable from the masters plays no part in arbitration.
    logic unused_penable;
    assign unused_penable = &{1'b0, m0.penable, m1.penable};

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter (TIMEOUT=4): tie round-robin, single write,
// wait states, timeout, slave error and reset during a stalled ACCESS.
module tb_apb_arbiter;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic [1:0] gnt;

    apb_arbiter_if m0_bus ();
    apb_arbiter_if m1_bus ();
    apb_arbiter_if mem_bus ();

    apb_arbiter #(.TIMEOUT(4)) dut (
        .pclk_i   (pclk),
        .preset_i (preset),
        .m0       (m0_bus),
        .m1       (m1_bus),
        .mem      (mem_bus),
        .gnt_o    (gnt)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Registered outputs are settled 2 time units after the edge.
    task automatic step();
        @(posedge pclk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psel"},    32'(mem_bus.psel),    32'h0);
        check({tag, "_penable"}, 32'(mem_bus.penable), 32'h0);
        check({tag, "_pwrite"},  32'(mem_bus.pwrite),  32'h0);
        check({tag, "_paddr"},   32'(mem_bus.paddr),   32'h0);
        check({tag, "_pwdata"},  mem_bus.pwdata,       32'h0);
        check({tag, "_gnt"},     32'(gnt),             32'h0);
        check({tag, "_m0rdy"},   32'(m0_bus.pready),   32'h0);
        check({tag, "_m1rdy"},   32'(m1_bus.pready),   32'h0);
        check({tag, "_m0err"},   32'(m0_bus.pslverr),  32'h0);
        check({tag, "_m0data"},  m0_bus.prdata,        32'h0);
    endtask

    initial begin
        m0_bus.psel = 0; m0_bus.penable = 0; m0_bus.pwrite = 0; m0_bus.paddr = 0; m0_bus.pwdata = 0;
        m1_bus.psel = 0; m1_bus.penable = 0; m1_bus.pwrite = 0; m1_bus.paddr = 0; m1_bus.pwdata = 0;
        mem_bus.prdata = 0; mem_bus.pready = 0; mem_bus.pslverr = 0;

        // Reset state
        step();
        step();
        check_reset_outputs("rst");
        preset = 1'b0;

        // Tie from reset: m0 first, then m1
        m0_bus.psel = 1; m0_bus.pwrite = 1; m0_bus.paddr = 8'h20; m0_bus.pwdata = 32'h1111_1111;
        m1_bus.psel = 1; m1_bus.pwrite = 0; m1_bus.paddr = 8'h30;
        mem_bus.pready = 1; mem_bus.prdata = 32'hCAFE_F00D;
        step();
        check("tie1_gnt", 32'(gnt), 32'h1);
        check("tie1_paddr", 32'(mem_bus.paddr), 32'h20);
        check("tie1_setup_m1rdy", 32'(m1_bus.pready), 32'h0);
        step();
        check("tie1_m0rdy", 32'(m0_bus.pready), 32'h1);
        check("tie1_m0data", m0_bus.prdata, 32'hCAFE_F00D);
        check("tie1_m1rdy", 32'(m1_bus.pready), 32'h0);
        check("tie1_m1data", m1_bus.prdata, 32'h0);
        m0_bus.psel = 0;
        step();
        check("tie_idle_gnt", 32'(gnt), 32'h0);
        check("tie_idle_psel", 32'(mem_bus.psel), 32'h0);
        step();
        check("tie2_gnt", 32'(gnt), 32'h2);
        check("tie2_paddr", 32'(mem_bus.paddr), 32'h30);
        check("tie2_pwrite", 32'(mem_bus.pwrite), 32'h0);
        step();
        check("tie2_m1rdy", 32'(m1_bus.pready), 32'h1);
        check("tie2_m1data", m1_bus.prdata, 32'hCAFE_F00D);
        check("tie2_m0rdy", 32'(m0_bus.pready), 32'h0);
        m1_bus.psel = 0;
        step();

        // Single write; pready_i high during IDLE must be ignored
        m0_bus.psel = 1; m0_bus.pwrite = 1; m0_bus.paddr = 8'h04; m0_bus.pwdata = 32'hDEAD_BEEF;
        mem_bus.pready = 1; mem_bus.prdata = 32'h0;
        #1;
        check("wr_idle_m0rdy", 32'(m0_bus.pready), 32'h0);
        step();
        check("wr_setup_psel", 32'(mem_bus.psel), 32'h1);
        check("wr_setup_pen", 32'(mem_bus.penable), 32'h0);
        check("wr_setup_gnt", 32'(gnt), 32'h1);
        step();
        check("wr_acc_pen", 32'(mem_bus.penable), 32'h1);
        check("wr_acc_m0rdy", 32'(m0_bus.pready), 32'h1);
        check("wr_acc_paddr", 32'(mem_bus.paddr), 32'h04);
        check("wr_acc_pwdata", mem_bus.pwdata, 32'hDEAD_BEEF);
        check("wr_acc_pwrite", 32'(mem_bus.pwrite), 32'h1);
        check("wr_acc_gnt", 32'(gnt), 32'h1);
        m0_bus.psel = 0;
        step();
        check("wr_idle_psel", 32'(mem_bus.psel), 32'h0);
        check("wr_idle_paddr_hold", 32'(mem_bus.paddr), 32'h04);

        // m1 read with 3 wait states; m1 drops psel mid-transfer
        mem_bus.pready = 0;
        m1_bus.psel = 1; m1_bus.pwrite = 0; m1_bus.paddr = 8'h10;
        step();
        check("ws_setup_gnt", 32'(gnt), 32'h2);
        m1_bus.psel = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("ws_wait%0d_m1rdy", i), 32'(m1_bus.pready), 32'h0);
            check($sformatf("ws_wait%0d_pen", i), 32'(mem_bus.penable), 32'h1);
            check($sformatf("ws_wait%0d_gnt", i), 32'(gnt), 32'h2);
        end
        step();
        mem_bus.pready = 1; mem_bus.prdata = 32'h1234_5678;
        #1;
        check("ws_m1rdy", 32'(m1_bus.pready), 32'h1);
        check("ws_m1data", m1_bus.prdata, 32'h1234_5678);
        check("ws_m1err", 32'(m1_bus.pslverr), 32'h0);
        step();
        check("ws_idle_psel", 32'(mem_bus.psel), 32'h0);

        // Timeout: slave never answers
        mem_bus.pready = 0; mem_bus.prdata = 32'hFFFF_FFFF;
        m0_bus.psel = 1; m0_bus.pwrite = 0; m0_bus.paddr = 8'h44;
        step();
        check("to_setup_gnt", 32'(gnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("to_acc%0d_m0rdy", i), 32'(m0_bus.pready), 32'h0);
        end
        step();
        check("to_m0rdy", 32'(m0_bus.pready), 32'h1);
        check("to_m0err", 32'(m0_bus.pslverr), 32'h1);
        check("to_m0data", m0_bus.prdata, 32'h0);
        m0_bus.psel = 0;
        step();
        check("to_idle_psel", 32'(mem_bus.psel), 32'h0);
        check("to_idle_m0rdy", 32'(m0_bus.pready), 32'h0);

        // Slave error on an m0 write: one cycle only
        m0_bus.psel = 1; m0_bus.pwrite = 1; m0_bus.paddr = 8'h08; m0_bus.pwdata = 32'h5A5A_5A5A;
        step();
        step();
        mem_bus.pready = 1; mem_bus.pslverr = 1; mem_bus.prdata = 32'h0;
        #1;
        check("err_m0rdy", 32'(m0_bus.pready), 32'h1);
        check("err_m0err", 32'(m0_bus.pslverr), 32'h1);
        m0_bus.psel = 0;
        step();
        check("err_idle_m0err", 32'(m0_bus.pslverr), 32'h0);
        mem_bus.pready = 0; mem_bus.pslverr = 0;

        // Reset during a stalled m0 ACCESS
        m0_bus.psel = 1; m0_bus.pwrite = 1; m0_bus.paddr = 8'h50; m0_bus.pwdata = 32'hA5A5_A5A5;
        step();
        step();
        step();
        check("rm_stall_pen", 32'(mem_bus.penable), 32'h1);
        preset = 1; mem_bus.pready = 1; mem_bus.prdata = 32'h7777_7777;
        #1;
        check("rm_abort_m0rdy", 32'(m0_bus.pready), 32'h0);
        step();
        check_reset_outputs("rm");
        preset = 0; mem_bus.pready = 0;
        m1_bus.psel = 1; m1_bus.paddr = 8'h60;
        step();
        check("rm_tie_gnt", 32'(gnt), 32'h1);
        check("rm_tie_paddr", 32'(mem_bus.paddr), 32'h50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
